// File: rtl/audio_meter_pkg.sv
// Shared constants and types for the audio level meter and anything that consumes its
// 0..8 level index (volume control, AGC).
package audio_meter_pkg;

    localparam int LEVEL_W   = 4;
    localparam int LEVEL_MAX = 8;

    typedef logic [LEVEL_W-1:0] level_t;

    // Entry i is the smallest peak that reaches level i+1; 6 dB apart.
    localparam logic [15:0] LEVEL_THRESH [LEVEL_MAX] = '{
        16'd128, 16'd256, 16'd512, 16'd1024,
        16'd2048, 16'd4096, 16'd8192, 16'd16384
    };

endpackage

// File: rtl/audio_level_meter_quantize.sv
// Maps an unsigned peak magnitude onto the 0..8 level index in 6 dB steps.
module level_quantize
    import audio_meter_pkg::*;
(
    input  logic [15:0] i_peak,
    output level_t      o_q
);

    always_comb begin
        o_q = '0;
        for (int i = 0; i < LEVEL_MAX; i++) begin
            if (i_peak >= LEVEL_THRESH[i]) begin
                o_q = level_t'(i + 1);
            end
        end
    end

endmodule

// File: rtl/audio_level_meter.sv
// Windowed peak meter: abs stage, per-window max, quantised level with instant attack
// and slow release, plus a sticky clip flag.
module audio_level_meter
    import audio_meter_pkg::*;
#(
    parameter int WINDOW_LEN      = 480,
    parameter int RELEASE_WINDOWS = 4,
    parameter int CLIP_THRESH     = 32767
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    input  logic               clip_clr,
    output level_t             level,
    output logic               level_valid,
    output logic [15:0]        peak,
    output logic               clip
);

    localparam int CNT_W = $clog2(WINDOW_LEN);
    localparam int RC_W  = $clog2(RELEASE_WINDOWS + 1);

    // -32768 has no positive twin in 16 bits, so it pins to full scale.
    function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
        if (x == -16'sd32768) begin
            return 16'd32767;
        end else if (x < 0) begin
            return 16'(-x);
        end
        return 16'(x);
    endfunction

    logic [15:0]      w_abs;
    logic [15:0]      r_abs_p1;
    logic             r_vld_p1;
    logic [15:0]      r_acc_p2;
    logic [CNT_W-1:0] r_win_cnt_p2;
    logic [RC_W-1:0]  r_rel_cnt;
    logic [RC_W-1:0]  w_rel_inc;
    logic [RC_W-1:0]  w_rel_nxt;
    logic [15:0]      w_peak_new;
    logic             w_win_last;
    level_t           w_q;
    level_t           w_level_nxt;

    assign w_abs = sat_abs(sample_in);

    // ---- stage 1: magnitude register and clip detection ----
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            r_abs_p1 <= w_abs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            clip     <= 1'b0;
        end else begin
            r_vld_p1 <= sample_valid;
            if (sample_valid && (w_abs >= 16'(CLIP_THRESH))) begin
                clip <= 1'b1;
            end else if (clip_clr) begin
                clip <= 1'b0;
            end
        end
    end

    // ---- stage 2: window max, quantise, ballistics ----
    assign w_peak_new = (r_abs_p1 > r_acc_p2) ? r_abs_p1 : r_acc_p2;
    assign w_win_last = (r_win_cnt_p2 == CNT_W'(WINDOW_LEN - 1));
    assign w_rel_inc  = r_rel_cnt + RC_W'(1);

    level_quantize u_quant (
        .i_peak (w_peak_new),
        .o_q    (w_q)
    );

    always_comb begin
        w_level_nxt = level;
        w_rel_nxt   = r_rel_cnt;
        if (w_q > level) begin
            w_level_nxt = w_q;
            w_rel_nxt   = '0;
        end else if (w_q == level) begin
            w_rel_nxt = '0;
        end else if (w_rel_inc == RC_W'(RELEASE_WINDOWS)) begin
            w_level_nxt = level - level_t'(1);
            w_rel_nxt   = '0;
        end else begin
            w_rel_nxt = w_rel_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_p2     <= '0;
            r_win_cnt_p2 <= '0;
            r_rel_cnt    <= '0;
            level        <= '0;
            level_valid  <= 1'b0;
            peak         <= '0;
        end else begin
            level_valid <= 1'b0;
            if (r_vld_p1) begin
                if (w_win_last) begin
                    peak         <= w_peak_new;
                    level        <= w_level_nxt;
                    r_rel_cnt    <= w_rel_nxt;
                    level_valid  <= 1'b1;
                    r_acc_p2     <= '0;
                    r_win_cnt_p2 <= '0;
                end else begin
                    r_acc_p2     <= w_peak_new;
                    r_win_cnt_p2 <= r_win_cnt_p2 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: directed scenarios plus random traffic checked every
// cycle against a window/queue based reference model.
module tb_audio_level_meter;

    localparam int WL = 4;
    localparam int RW = 2;
    localparam int CT = 32767;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               clip_clr = 1'b0;
    logic [3:0]         level;
    logic               level_valid;
    logic [15:0]        peak;
    logic               clip;

    audio_level_meter #(
        .WINDOW_LEN      (WL),
        .RELEASE_WINDOWS (RW),
        .CLIP_THRESH     (CT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clip_clr     (clip_clr),
        .level        (level),
        .level_valid  (level_valid),
        .peak         (peak),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_strobe = 0;
    bit chk_en = 1'b0;

    typedef struct { int due; int p; } pend_t;
    pend_t pend[$];
    int    wbuf[$];
    int    m_level = 0;
    int    m_peak = 0;
    int    m_lower = 0;
    bit    m_clip = 1'b0;
    bit    m_lv = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // 6 dB per step above 128: count doublings of the threshold the peak still clears.
    function automatic int quant(input int p);
        int q = 0;
        int t = 128;
        while (q < 8 && p >= t) begin
            q++;
            t = t * 2;
        end
        return q;
    endfunction

    // Reference model, advanced on every rising edge from the inputs the DUT sees.
    initial forever begin
        int s, a, mx, q, p;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            pend.delete();
            wbuf.delete();
            m_level = 0; m_peak = 0; m_lower = 0; m_clip = 0; m_lv = 0;
        end else begin
            m_lv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend[0].p;
                pend.pop_front();
                m_lv = 1;
                m_peak = p;
                q = quant(p);
                if (q > m_level) begin
                    m_level = q;
                    m_lower = 0;
                end else if (q == m_level) begin
                    m_lower = 0;
                end else begin
                    m_lower++;
                    if (m_lower == RW) begin
                        m_level--;
                        m_lower = 0;
                    end
                end
            end
            if (sample_valid) begin
                s = sample_in;
                a = (s < 0) ? ((s == -32768) ? 32767 : -s) : s;
                if (a >= CT) m_clip = 1;
                else if (clip_clr) m_clip = 0;
                wbuf.push_back(a);
                if (wbuf.size() == WL) begin
                    mx = 0;
                    foreach (wbuf[i]) if (wbuf[i] > mx) mx = wbuf[i];
                    pend.push_back('{cyc + 1, mx});
                    wbuf.delete();
                end
            end else if (clip_clr) begin
                m_clip = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_level", int'(level), 0);
                chk("rst_peak", int'(peak), 0);
                chk("rst_lv", int'(level_valid), 0);
                chk("rst_clip", int'(clip), 0);
            end else begin
                chk("level", int'(level), m_level);
                chk("peak", int'(peak), m_peak);
                chk("level_valid", int'(level_valid), int'(m_lv));
                chk("clip", int'(clip), int'(m_clip));
            end
        end
    end

    task automatic send(input int s, input bit clr);
        sample_in    = 16'(s);
        sample_valid = 1'b1;
        clip_clr     = clr;
        last_strobe  = cyc;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clip_clr     = 1'b0;
    endtask

    task automatic send_win(input int s0, input int s1, input int s2, input int s3);
        send(s0, 1'b0);
        send(s1, 1'b0);
        send(s2, 1'b0);
        send(s3, 1'b0);
    endtask

    task automatic wait_lv(input string nm);
        int seen = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (level_valid) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) chk({nm, "_timeout"}, 0, 1);
        else chk({nm, "_latency"}, seen - last_strobe, 2);
    endtask

    initial begin
        int lvl_exp [5] = '{8, 7, 7, 6, 6};
        int rs;
        logic [15:0] raw;

        // Scenario 1: reset, then idle with no samples.
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t1_level", int'(level), 0);
        chk("t1_peak", int'(peak), 0);
        chk("t1_clip", int'(clip), 0);
        chk("t1_lv", int'(level_valid), 0);

        // Scenario 2: one ordinary window.
        send_win(100, -300, 200, 50);
        wait_lv("t2");
        chk("t2_peak", int'(peak), 300);
        chk("t2_level", int'(level), 2);
        chk("t2_clip", int'(clip), 0);

        // Scenario 3: most-negative sample, clip set/clear priority.
        send_win(-32768, 0, 0, 0);
        wait_lv("t3a");
        chk("t3_peak", int'(peak), 32767);
        chk("t3_level", int'(level), 8);
        chk("t3_clip", int'(clip), 1);
        send(32767, 1'b1);
        chk("t3_clip_setwins", int'(clip), 1);
        send(0, 1'b0);
        send(0, 1'b0);
        send(0, 1'b0);
        wait_lv("t3b");
        chk("t3b_level", int'(level), 8);
        clip_clr = 1'b1;
        @(posedge clk);
        #1;
        clip_clr = 1'b0;
        chk("t3_clip_cleared", int'(clip), 0);

        // Scenario 4: release from level 8 with silent windows.
        for (int w = 0; w < 5; w++) begin
            send_win(0, 0, 0, 0);
            wait_lv("t4");
            chk("t4_level", int'(level), lvl_exp[w]);
        end

        // Scenario 5: equal-level window resets the release count; attack is instant.
        send_win(5000, 0, 0, 0);
        wait_lv("t5a");
        chk("t5_hold", int'(level), 6);
        send_win(0, 0, 0, 0);
        wait_lv("t5b");
        chk("t5_cnt_reset", int'(level), 6);
        send_win(0, 20000, 0, 0);
        wait_lv("t5c");
        chk("t5_attack", int'(level), 8);
        chk("t5_peak", int'(peak), 20000);

        // Scenario 6: reset in mid-window discards the partial window.
        send(20000, 1'b0);
        send(20000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_level_rst", int'(level), 0);
        chk("t6_peak_rst", int'(peak), 0);
        send_win(300, 300, 300, 300);
        wait_lv("t6");
        chk("t6_peak", int'(peak), 300);
        chk("t6_level", int'(level), 2);

        // Random traffic with gaps, clears and full-scale samples.
        for (int i = 0; i < 3000; i++) begin
            raw = 16'($urandom);
            rs  = $urandom_range(0, 99);
            if (rs < 2) sample_in = -16'sd32768;
            else if (rs < 4) sample_in = 16'sd32767;
            else sample_in = $signed(raw) >>> $urandom_range(0, 15);
            sample_valid = ($urandom_range(0, 9) < 7);
            clip_clr     = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        clip_clr     = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_pending", pend.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
- Measures the signed 16-bit sample stream and reports its level as a 0..8 index in 6 dB steps, the same index scale that volume_adjust consumes on volume[3:0].
- Sits in parallel with or after volume_adjust to drive level LEDs, PS-readable meter registers, or a future AGC loop that feeds volume back.
- Sequential block: windowed peak detection, attack/release ballistics, sticky clip detection.

Parameters:
- WINDOW_LEN, 480, samples per measurement window (10 ms at 48 kHz); minimum 2.
- RELEASE_WINDOWS, 4, consecutive lower-level windows required before level drops one step; minimum 1.
- CLIP_THRESH, 32767, absolute value at or above which clip is flagged.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_in  in  16  signed audio sample (shortint).
- sample_valid  in  1  one-cycle strobe qualifying sample_in.
- clip_clr  in  1  synchronous clear of the sticky clip flag.
- level  out  4  current metered level, 0..8.
- level_valid  out  1  one-cycle pulse when a window closes; level is updated in the same cycle.
- peak  out  16  unsigned peak |sample| of the last closed window.
- clip  out  1  sticky clip flag.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0. Window counter, peak accumulator, release counter and pipeline valid are all 0.
- Stage 1 (cycle after sample_valid): registered abs value.
  - -32768 saturates to 32767.
  - Positive values pass unchanged.
- Stage 2 (next cycle): peak accumulator updates to max(acc, abs). Window counter increments and wraps at WINDOW_LEN-1.
- Window close: when stage 2 handles the window's last sample, the following occur in that same stage-2 cycle.
  - peak is set to the final max, including the last sample.
  - level_valid pulses 1.
  - level is updated.
  - Accumulator restarts at 0.
- Latency: level_valid occurs exactly 2 cycles after the sample_valid of the window's last sample.
- Back-to-back samples every cycle are supported. A sample entering stage 2 in the close cycle belongs to the next window.
- Quantisation of the window peak p to index q:
  - p >= 16384 gives 8; >= 8192 gives 7; >= 4096 gives 6; >= 2048 gives 5; >= 1024 gives 4; >= 512 gives 3; >= 256 gives 2; >= 128 gives 1.
  - Any smaller p gives 0.
- Ballistics, evaluated only at window close:
  - q > level: level = q (instant attack); release counter = 0.
  - q == level: release counter = 0.
  - q < level: release counter + 1. When it reaches RELEASE_WINDOWS, level decrements by 1 (never by more) and the counter returns to 0.
  - level never underflows below 0.
- Clip flag:
  - Set when a stage-1 abs value >= CLIP_THRESH.
  - Cleared by clip_clr.
  - Set and clear in the same cycle: set wins, clip stays 1.
  - Independent of window timing.
- Reset mid-window: the partial window is discarded. The first window after reset needs a full WINDOW_LEN samples.
- sample_valid low: no state changes except clip_clr.

Decomposition:
- Shared package audio_meter_pkg holds:
  - LEVEL_W = 4 and LEVEL_MAX = 8.
  - Threshold constant array of 8 entries (128..16384).
  - Typedef level_t of type logic [3:0].
- One combinational sub-module, level_quantize (peak to q), reused later by the AGC.
- Ballistics counter and window counter stay in the top module.

Test Plan (WINDOW_LEN=4, RELEASE_WINDOWS=2, CLIP_THRESH=32767):
1. Hold rst_n low, then release with no samples -> level=0, peak=0, clip=0, no level_valid pulse.
2. Samples {100, -300, 200, 50} on consecutive cycles -> level_valid pulses 2 cycles after the 4th strobe; peak=300, level=2, clip=0.
3. Sample -32768 in a window, others 0 -> peak=32767, level=8, clip=1. Then clip_clr in the same cycle as a new +32767 clip sample -> clip stays 1. A later clip_clr with no clip -> clip=0.
4. From level 8, feed all-zero windows -> level is 8 after window 1 and 7 after window 2. It reaches 6 after window 4, and decrements by 1 every 2 windows after that.
5. At level 6 with release counter 1, a window with peak 5000 gives q=6 -> counter resets and level stays 6. The next window with peak 20000 -> level=8 immediately.
6. Feed 2 samples of 20000, pulse rst_n low for 1 cycle, then feed 4 samples of 300 -> single level_valid only after the 4th post-reset sample; peak=300, level=2.
